// File: rtl/bus_rr_scheduler_pkg.sv
// Shared definitions for the 2-master / 3-slave system bus: FSM encoding,
// master ids and slave id width, used by the scheduler and the bus muxes.
package bus_rr_scheduler_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_XFER    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam logic MASTER_1 = 1'b0;
   localparam logic MASTER_2 = 1'b1;

   localparam int                    SLAVE_ID_W  = 2;
   localparam int                    NUM_SLAVES  = 3;
   localparam logic [SLAVE_ID_W-1:0] SLV_INVALID = 2'd3;

endpackage

// File: rtl/bus_rr_scheduler_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags the last
// permitted cycle so the scheduler can force a release.
module bus_rr_scheduler_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      cnt <= '0;
      else if (clear)  cnt <= '0;
      else if (enable) cnt <= cnt + CNT_W'(1);
   end

   assign expire = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin transaction scheduler: grants one master per transaction,
// drives the master/slave mux selects and releases on done, drop or timeout.
module bus_rr_scheduler
   import bus_rr_scheduler_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m1_request,
   input  logic [SLAVE_ID_W-1:0] m1_slave_select,
   input  logic                  m1_tx_done,
   input  logic                  m2_request,
   input  logic [SLAVE_ID_W-1:0] m2_slave_select,
   input  logic                  m2_tx_done,
   input  logic [NUM_SLAVES-1:0] slave_ready,
   output logic                  m1_grant,
   output logic                  m2_grant,
   output logic                  bus_grant,
   output logic [SLAVE_ID_W-1:0] slave_grant,
   output logic                  busy,
   output logic                  timeout_err,
   output logic                  sel_err
);

   state_t                      state;
   logic                        last_winner;
   logic                        win_m2;
   logic [SLAVE_ID_W-1:0]       win_sel;
   logic                        own_req;
   logic                        own_done;
   logic                        wd_en;
   logic                        expire;
   logic [2**SLAVE_ID_W-1:0]    rdy_ext;

   // Tie goes to whichever master did not win last.
   assign win_m2   = m2_request && (!m1_request || (last_winner == MASTER_1));
   assign win_sel  = win_m2 ? m2_slave_select : m1_slave_select;
   assign own_req  = (bus_grant == MASTER_2) ? m2_request : m1_request;
   assign own_done = (bus_grant == MASTER_2) ? m2_tx_done : m1_tx_done;
   assign rdy_ext  = {{(2**SLAVE_ID_W - NUM_SLAVES){1'b0}}, slave_ready};
   assign wd_en    = (state == S_GRANT) || (state == S_XFER);

   bus_rr_scheduler_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (!wd_en),
      .enable (wd_en),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         last_winner <= MASTER_2;
         m1_grant    <= 1'b0;
         m2_grant    <= 1'b0;
         bus_grant   <= MASTER_1;
         slave_grant <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         sel_err     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (m1_request || m2_request) begin
                  if (win_sel == SLV_INVALID) begin
                     // Rotate past the offender so it cannot lock out the other master.
                     sel_err     <= 1'b1;
                     last_winner <= win_m2;
                  end else begin
                     state       <= S_GRANT;
                     m1_grant    <= !win_m2;
                     m2_grant    <= win_m2;
                     bus_grant   <= win_m2;
                     slave_grant <= win_sel;
                     busy        <= 1'b1;
                  end
               end
            end
            S_GRANT: begin
               if (!own_req) begin
                  state <= S_RELEASE;
                  m1_grant <= 1'b0;
                  m2_grant <= 1'b0;
               end else if (expire) begin
                  state       <= S_RELEASE;
                  m1_grant    <= 1'b0;
                  m2_grant    <= 1'b0;
                  timeout_err <= 1'b1;
               end else if (rdy_ext[slave_grant]) begin
                  state <= S_XFER;
               end
            end
            S_XFER: begin
               if (own_done || !own_req) begin
                  state    <= S_RELEASE;
                  m1_grant <= 1'b0;
                  m2_grant <= 1'b0;
               end else if (expire) begin
                  state       <= S_RELEASE;
                  m1_grant    <= 1'b0;
                  m2_grant    <= 1'b0;
                  timeout_err <= 1'b1;
               end
            end
            default: begin
               // Mux selects stay put through the release cycle for the last beat.
               state       <= S_IDLE;
               busy        <= 1'b0;
               last_winner <= bus_grant;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler with a transaction-level ownership model
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_bus_rr_scheduler;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       m1_request = 1'b0, m2_request = 1'b0;
   logic [1:0] m1_slave_select = 2'd0, m2_slave_select = 2'd0;
   logic       m1_tx_done = 1'b0, m2_tx_done = 1'b0;
   logic [2:0] slave_ready = 3'd0;
   logic       m1_grant, m2_grant, bus_grant, busy, timeout_err, sel_err;
   logic [1:0] slave_grant;

   bus_rr_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .m1_request      (m1_request),
      .m1_slave_select (m1_slave_select),
      .m1_tx_done      (m1_tx_done),
      .m2_request      (m2_request),
      .m2_slave_select (m2_slave_select),
      .m2_tx_done      (m2_tx_done),
      .slave_ready     (slave_ready),
      .m1_grant        (m1_grant),
      .m2_grant        (m2_grant),
      .bus_grant       (bus_grant),
      .slave_grant     (slave_grant),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .sel_err         (sel_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Ownership model: who holds the bus, how long it has held it, whether the
   // slave has answered, and whether this is the one-cycle release tail.
   int         own, last, slv, age;
   bit         rel, xfer;
   logic       e_m1, e_m2, e_bg, e_busy, e_to, e_se;
   logic [1:0] e_sg;

   task automatic model_reset();
      own = 0; last = 2; slv = 0; age = 0; rel = 0; xfer = 0;
      e_m1 = 0; e_m2 = 0; e_bg = 0; e_busy = 0; e_to = 0; e_se = 0; e_sg = 0;
   endtask

   task automatic model_step();
      int w, s;
      bit req, done;
      e_to = 0;
      e_se = 0;
      if (rel) begin
         rel = 0; last = own; own = 0; e_busy = 0;
      end else if (own == 0) begin
         if (m1_request || m2_request) begin
            if (m1_request && m2_request) w = (last == 1) ? 2 : 1;
            else                          w = m1_request ? 1 : 2;
            s = (w == 1) ? int'(m1_slave_select) : int'(m2_slave_select);
            if (s == 3) begin
               e_se = 1; last = w;
            end else begin
               own = w; slv = s; age = 0; xfer = 0;
               e_busy = 1; e_bg = (w == 2); e_sg = 2'(s);
            end
         end
      end else begin
         req  = (own == 1) ? m1_request : m2_request;
         done = (own == 1) ? m1_tx_done : m2_tx_done;
         if ((xfer && done) || !req) begin
            rel = 1;
         end else if (age == TIMEOUT - 1) begin
            rel = 1; e_to = 1;
         end else begin
            if (!xfer && slave_ready[slv]) xfer = 1;
            age++;
         end
      end
      e_m1 = (own == 1) && !rel;
      e_m2 = (own == 2) && !rel;
   endtask

   always @(negedge reset) model_reset();
   always @(posedge clk) if (reset) model_step();

   always @(negedge clk) begin
      chk("grants/busy/errs", int'({m1_grant, m2_grant, busy, timeout_err, sel_err}),
          int'({e_m1, e_m2, e_busy, e_to, e_se}));
      if (e_busy) chk("mux selects", int'({bus_grant, slave_grant}), int'({e_bg, e_sg}));
      chk("grant exclusive/implies busy",
          int'((m1_grant && m2_grant) || ((m1_grant || m2_grant) && !busy)), 0);
   end

   task automatic wait_grant(output int who);
      who = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (m1_grant) begin who = 1; break; end
         if (m2_grant) begin who = 2; break; end
      end
      if (who == 0) begin
         n_vec++; n_err++;
         $display("FAIL wait_grant: no grant within 20 cycles at %0t", $time);
      end
   endtask

   initial begin
      int who;
      model_reset();
      #2;
      chk("reset grants", int'({m1_grant, m2_grant}), 0);
      chk("reset busy/errs", int'({busy, timeout_err, sel_err}), 0);
      chk("reset selects", int'({bus_grant, slave_grant}), 0);
      tick(2); reset = 1'b1;
      tick(1);

      // Single m1 transaction to slave 1
      m1_request = 1; m1_slave_select = 2'd1;
      tick(1);
      chk("t1 m1_grant", int'(m1_grant), 1);
      chk("t1 slave_grant", int'(slave_grant), 1);
      chk("t1 bus_grant", int'(bus_grant), 0);
      tick(2); slave_ready = 3'b010;
      tick(3); m1_tx_done = 1;
      chk("t6 m1_grant", int'(m1_grant), 1);
      tick(1); m1_tx_done = 0; m1_request = 0; slave_ready = 0;
      chk("t7 release m1_grant", int'(m1_grant), 0);
      chk("t7 release busy", int'(busy), 1);
      chk("t7 release slave_grant", int'(slave_grant), 1);
      tick(1);
      chk("t8 idle busy", int'(busy), 0);

      // Round robin from reset: m1, m2, m1, m2
      reset = 0; tick(1); reset = 1;
      slave_ready = 3'b111; m1_slave_select = 2'd0; m2_slave_select = 2'd2;
      m1_request = 1; m2_request = 1;
      for (int k = 0; k < 4; k++) begin
         wait_grant(who);
         chk("rr winner", who, (k % 2 == 0) ? 1 : 2);
         tick(1);
         if (who == 1) m1_tx_done = 1; else m2_tx_done = 1;
         tick(1);
         m1_tx_done = 0; m2_tx_done = 0;
         if (who == 1) m1_request = 0; else m2_request = 0;
         tick(1);
         if (who == 1) m1_request = 1; else m2_request = 1;
      end
      m1_request = 0; m2_request = 0; slave_ready = 0;
      tick(2);

      // Watchdog abort on m2 to slave 2 (never ready)
      m2_request = 1; m2_slave_select = 2'd2;
      tick(1);
      chk("wd t1 m2_grant", int'(m2_grant), 1);
      tick(7);
      chk("wd t8 m2_grant", int'(m2_grant), 1);
      chk("wd t8 timeout_err", int'(timeout_err), 0);
      tick(1);
      chk("wd t9 timeout_err", int'(timeout_err), 1);
      chk("wd t9 m2_grant", int'(m2_grant), 0);
      chk("wd t9 busy", int'(busy), 1);
      m2_request = 0;
      tick(1);
      chk("wd t10 timeout_err", int'(timeout_err), 0);

      // m2 drops request in XFER; m1 pending; m1's done during m2 ignored
      m2_request = 1; m2_slave_select = 2'd0; slave_ready = 3'b001;
      tick(1);
      chk("drop t1 m2_grant", int'(m2_grant), 1);
      m1_request = 1; m1_slave_select = 2'd1;
      tick(1); m1_tx_done = 1;
      tick(1); m1_tx_done = 0;
      chk("drop t3 m2_grant holds", int'(m2_grant), 1);
      m2_request = 0;
      tick(1);
      chk("drop t4 m2_grant", int'(m2_grant), 0);
      chk("drop t4 busy", int'(busy), 1);
      chk("drop t4 timeout_err", int'(timeout_err), 0);
      tick(2);
      chk("drop t6 m1_grant", int'(m1_grant), 1);
      chk("drop t6 selects", int'({bus_grant, slave_grant}), 1);
      slave_ready = 3'b011;
      tick(1); m1_tx_done = 1;
      tick(1); m1_tx_done = 0; m1_request = 0; slave_ready = 0;
      tick(1);

      // tx_done on the watchdog's last cycle wins: no error
      m1_request = 1; m1_slave_select = 2'd0; slave_ready = 3'b001;
      tick(8); m1_tx_done = 1;
      tick(1);
      chk("done vs wd timeout_err", int'(timeout_err), 0);
      chk("done vs wd busy", int'(busy), 1);
      m1_tx_done = 0; m1_request = 0; slave_ready = 0;
      tick(1);

      // Reset mid-XFER
      m2_request = 1; m2_slave_select = 2'd0; slave_ready = 3'b001;
      tick(1);
      m1_request = 1; m1_slave_select = 2'd2;
      tick(2);
      chk("pre-reset m2_grant", int'(m2_grant), 1);
      #3 reset = 0;
      #1;
      chk("async reset outputs",
          int'({m1_grant, m2_grant, bus_grant, slave_grant, busy, timeout_err, sel_err}), 0);
      tick(1); reset = 1;
      tick(1);
      chk("post-reset tie m1_grant", int'(m1_grant), 1);
      chk("post-reset tie m2_grant", int'(m2_grant), 0);
      slave_ready = 3'b100;
      tick(1); m1_tx_done = 1;
      tick(1); m1_tx_done = 0; m1_request = 0; m2_request = 0; slave_ready = 0;
      tick(1);

      // Invalid select, then m2 granted normally
      m1_request = 1; m1_slave_select = 2'd3;
      tick(1);
      chk("sel t1 sel_err", int'(sel_err), 1);
      chk("sel t1 grants/busy", int'({m1_grant, m2_grant, busy}), 0);
      m1_request = 0; m2_request = 1; m2_slave_select = 2'd1; slave_ready = 3'b010;
      tick(1);
      chk("sel t2 sel_err", int'(sel_err), 0);
      chk("sel t2 m2_grant", int'(m2_grant), 1);
      chk("sel t2 selects", int'({bus_grant, slave_grant}), 3'b101);
      tick(1); m2_tx_done = 1;
      tick(1); m2_tx_done = 0; m2_request = 0; slave_ready = 0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global time limit reached at %0t", $time);
      $fatal(1, "time limit");
   end

endmodule
